// File: rtl/frame_transmitter_if.sv
// Host-side bundle for the serial frame transmitter: the word/reset request
// handshake, completion/busy status and the serial line itself.
// Ports: tx_data/tx_valid/tx_reset_req (host->tx), tx_ready/tx_done/busy/so (tx->host/line).
interface frame_transmitter_if #(
  parameter int DATA_BITS = 40
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_reset_req;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 busy;
  logic                 so;

  modport master (
    output tx_data, tx_valid, tx_reset_req,
    input  tx_ready, tx_done, busy, so
  );

  modport slave (
    input  tx_data, tx_valid, tx_reset_req,
    output tx_ready, tx_done, busy, so
  );
endinterface

// File: rtl/frame_transmitter.sv
// Serial frame transmitter: START(1), DATA_BITS data MSB first, PAD(0), TRAILER
// (1 only for a link-reset frame), then RST_HOLD (reset frames) and GAP.
// Ports: clk, reset (sync, active-high), link (slave modport of frame_transmitter_if).
// Optional FRAME_TX_QUEUE_EN: one-entry holding register allowing back-to-back frames.
module frame_transmitter #(
  parameter int DATA_BITS  = 40,
  parameter int GAP_BITS   = 1,
  parameter int RESET_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_transmitter_if.slave   link
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAD, TRAILER, RST_HOLD, GAP
  } state_t;

  localparam logic [5:0] BIT_TOP  = 6'(DATA_BITS - 1);
  localparam logic [7:0] GAP_TOP  = 8'(GAP_BITS - 1);
  localparam logic [7:0] HOLD_TOP = 8'(RESET_HOLD - 1);

  state_t               state, state_nxt;
  logic [5:0]           bit_cnt, bit_cnt_nxt;
  logic [7:0]           hold_cnt, hold_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 rst_frame, rst_frame_nxt;
  logic                 so_q, so_nxt;
  logic                 done_q;

  logic                 acc;
  logic                 want_idle;
  logic                 launch_hold;
  logic                 launch_in;

  logic                 hold_vld;
  logic [DATA_BITS-1:0] hold_dat;
  logic                 hold_rst;

`ifdef FRAME_TX_QUEUE_EN
  // The holding register is always empty in IDLE (it is promoted on the way in),
  // so this reduces to "holding empty" while still reading naturally.
  assign link.tx_ready = ~reset & ((state == IDLE) | ~hold_vld);
`else
  assign link.tx_ready = ~reset & (state == IDLE);
`endif

  // A reset request wins over data; the data word simply stays pending.
  assign acc = link.tx_ready & (link.tx_valid | link.tx_reset_req);

  assign link.so      = so_q;
  assign link.tx_done = done_q;
  assign link.busy    = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    hold_cnt_nxt  = hold_cnt;
    shreg_nxt     = shreg;
    rst_frame_nxt = rst_frame;
    so_nxt        = 1'b0;
    want_idle     = 1'b0;
    launch_hold   = 1'b0;
    launch_in     = 1'b0;

    // so_nxt is the line value for the state being entered, so the registered
    // output lines up with the state it belongs to.
    case (state)
      IDLE: want_idle = 1'b1;

      START: begin
        state_nxt   = DATA;
        bit_cnt_nxt = BIT_TOP;
        so_nxt      = shreg[DATA_BITS-1];
        shreg_nxt   = shreg << 1;
      end

      DATA: begin
        if (bit_cnt == 6'd0) begin
          state_nxt = PAD;
        end else begin
          bit_cnt_nxt = bit_cnt - 6'd1;
          so_nxt      = shreg[DATA_BITS-1];
          shreg_nxt   = shreg << 1;
        end
      end

      PAD: begin
        state_nxt = TRAILER;
        so_nxt    = rst_frame;
      end

      TRAILER: begin
        if (rst_frame) begin
          state_nxt    = RST_HOLD;
          hold_cnt_nxt = HOLD_TOP;
          so_nxt       = 1'b1;
        end else if (GAP_BITS > 0) begin
          state_nxt    = GAP;
          hold_cnt_nxt = GAP_TOP;
        end else begin
          want_idle = 1'b1;
        end
      end

      RST_HOLD: begin
        if (hold_cnt == 8'd0) begin
          if (GAP_BITS > 0) begin
            state_nxt    = GAP;
            hold_cnt_nxt = GAP_TOP;
          end else begin
            want_idle = 1'b1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
          so_nxt       = 1'b1;
        end
      end

      GAP: begin
        if (hold_cnt == 8'd0) begin
          want_idle = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Every path back to IDLE funnels through here: a queued item takes priority,
    // then a request arriving this cycle, otherwise rest in IDLE.
    if (want_idle) begin
      if (hold_vld) begin
        launch_hold = 1'b1;
      end else if (acc) begin
        launch_in = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end

    if (launch_hold) begin
      state_nxt     = START;
      shreg_nxt     = hold_dat;
      rst_frame_nxt = hold_rst;
      so_nxt        = 1'b1;
    end else if (launch_in) begin
      state_nxt     = START;
      shreg_nxt     = link.tx_reset_req ? '1 : link.tx_data;
      rst_frame_nxt = link.tx_reset_req;
      so_nxt        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      hold_cnt  <= '0;
      shreg     <= '0;
      rst_frame <= 1'b0;
      so_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      hold_cnt  <= hold_cnt_nxt;
      shreg     <= shreg_nxt;
      rst_frame <= rst_frame_nxt;
      so_q      <= so_nxt;
      done_q    <= (state_nxt == TRAILER);
    end
  end

`ifdef FRAME_TX_QUEUE_EN
  // An accept that does not launch immediately can only happen mid-frame with
  // the holding register empty, so fill and drain never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
      hold_rst <= 1'b0;
    end else begin
      if (launch_hold) begin
        hold_vld <= 1'b0;
      end
      if (acc && !launch_in) begin
        hold_vld <= 1'b1;
        hold_dat <= link.tx_reset_req ? '1 : link.tx_data;
        hold_rst <= link.tx_reset_req;
      end
    end
  end
`else
  assign hold_vld = 1'b0;
  assign hold_dat = '0;
  assign hold_rst = 1'b0;
`endif

endmodule
